v810_bus_resp: RTL and testbench

- External-bus target (responder) for the V810 bus: decodes BCYSTn/DAn/MRQn/RW/BEn/A and drives READYn, SZRQn and read data.
- Bridges each bus cycle to a single backing-memory request/ack port.
- Sits outside the CPU, e.g. as the front end of a RAM/ROM/IO model on the system bus; optionally presents itself as a 16-bit device via dynamic bus sizing.

---
 rtl/v810_bus_resp.sv | 154 +++++++++++++++
 tb/tb_v810_bus_resp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v810_bus_resp.sv
// rtl/v810_bus_resp.sv - V810 external-bus responder bridging each bus cycle to a req/ack memory port
// Optional watchdog and ERR port: define V810_BUS_RESP_TIMEOUT_EN.
module v810_bus_resp #(
  parameter int WAIT_MIN = 0,
  parameter int BUS16    = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic [31:0] D_I,
  output logic [31:0] D_O,
  input  logic [3:0]  BEn,
  input  logic        DAn,
  input  logic        MRQn,
  input  logic        RW,
  input  logic        BCYSTn,
  output logic        READYn,
  output logic        SZRQn,
  output logic [29:0] M_A,
  output logic [3:0]  M_BE,
  output logic        M_WR,
  output logic [31:0] M_WD,
  output logic        M_REQ,
  input  logic [31:0] M_RD,
`ifdef V810_BUS_RESP_TIMEOUT_EN
  output logic        ERR,
`endif
  input  logic        M_ACK
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RDY  = 2'd3;

  localparam logic        LP_BUS16 = (BUS16 != 0);
  localparam logic [15:0] LP_WAIT  = 16'(WAIT_MIN);

  logic [1:0]  r_state;
  logic [1:0]  w_nstate;
  logic [29:0] r_addr;
  logic [3:0]  r_ben;
  logic        r_rw;
  logic        r_first;
  logic [31:0] r_wd;
  logic [31:0] r_do;
  logic [15:0] r_wcnt;

  logic        w_start;
  logic        w_upper;
  logic [3:0]  w_be;
  logic [3:0]  w_mbe;
  logic [31:0] w_wd_new;
  logic [31:0] w_rd;
  logic        w_wait_ok;
  logic        w_ack;
  logic        w_tmo;
  logic        w_unused;

  // A cycle starts on BCYSTn, or on DAn alone when the CPU skips T1.
  assign w_start   = !MRQn && (!BCYSTn || !DAn);
  assign w_upper   = (r_ben[1:0] == 2'b11);
  assign w_be      = ~r_ben;
  assign w_mbe     = LP_BUS16 ? (w_upper ? {w_be[3:2], 2'b00} : {2'b00, w_be[1:0]}) : w_be;
  assign w_wd_new  = LP_BUS16 ? {2{D_I[15:0]}} : D_I;
  assign w_rd      = LP_BUS16 ? (w_upper ? {2{M_RD[31:16]}} : {2{M_RD[15:0]}}) : M_RD;
  assign w_wait_ok = (r_wcnt >= LP_WAIT);
  assign w_ack     = (r_state == S_MEM) && M_ACK;
  assign w_unused  = &{1'b0, A[1:0]};

`ifdef V810_BUS_RESP_TIMEOUT_EN
  localparam logic [15:0] LP_TMO = 16'(TIMEOUT);
  logic [15:0] r_tcnt;
  logic        r_err;

  assign w_tmo = (r_state == S_MEM) && !M_ACK && (r_tcnt == LP_TMO - 16'd1);
  assign ERR   = r_err;

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_tcnt <= 16'd0;
      r_err  <= 1'b0;
    end else if (CE) begin
      r_err <= w_tmo;
      if (r_state == S_IDLE)
        r_tcnt <= 16'd0;
      else if (r_state == S_MEM && r_tcnt != 16'hFFFF)
        r_tcnt <= r_tcnt + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_nstate = S_MEM;
      S_MEM: begin
        if (M_ACK)
          w_nstate = w_wait_ok ? S_RDY : S_WAIT;
        else if (w_tmo)
          w_nstate = S_RDY;
      end
      S_WAIT: if (w_wait_ok) w_nstate = S_RDY;
      S_RDY:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state <= S_IDLE;
      r_addr  <= 30'd0;
      r_ben   <= 4'hF;
      r_rw    <= 1'b1;
      r_first <= 1'b0;
      r_wd    <= 32'd0;
      r_do    <= 32'd0;
      r_wcnt  <= 16'd0;
    end else if (CE) begin
      r_state <= w_nstate;
      r_first <= (r_state == S_IDLE) && w_start;
      if (r_state == S_IDLE && w_start) begin
        r_addr <= A[31:2];
        r_ben  <= BEn;
        r_rw   <= RW;
        r_wcnt <= 16'd0;
      end else if ((r_state == S_MEM || r_state == S_WAIT) && r_wcnt != 16'hFFFF) begin
        r_wcnt <= r_wcnt + 16'd1;
      end
      // D_I is only valid in T2, so write data is sampled in the first MEM cycle.
      if (r_first)
        r_wd <= w_wd_new;
      if (w_ack && r_rw)
        r_do <= w_rd;
      else if (w_tmo)
        r_do <= 32'hFFFF_FFFF;
    end
  end

  assign READYn = (r_state != S_RDY);
  assign SZRQn  = !(LP_BUS16 && r_state != S_IDLE);
  assign M_REQ  = (r_state == S_MEM);
  assign M_A    = r_addr;
  assign M_BE   = w_mbe;
  assign M_WR   = !r_rw;
  // First MEM cycle forwards D_I directly so a same-cycle ack sees valid data.
  assign M_WD   = r_first ? w_wd_new : r_wd;
  assign D_O    = r_do;

endmodule

// File: tb/tb_v810_bus_resp.sv
// tb/tb_v810_bus_resp.sv - directed bench for v810_bus_resp (three configurations side by side)
module tb_v810_bus_resp;

  logic        CLK = 1'b0;
  logic        RES, CE, DAn, MRQn, RW, BCYSTn, M_ACK;
  logic [31:0] A, D_I, M_RD;
  logic [3:0]  BEn;

  logic [31:0] d_o   [3];
  logic        readyn[3];
  logic        szrqn [3];
  logic [29:0] m_a   [3];
  logic [3:0]  m_be  [3];
  logic        m_wr  [3];
  logic [31:0] m_wd  [3];
  logic        m_req [3];
`ifdef V810_BUS_RESP_TIMEOUT_EN
  logic        err   [3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  // 0: 32-bit no waits, 1: 32-bit WAIT_MIN=3, 2: 16-bit no waits
  for (genvar g = 0; g < 3; g++) begin : g_dut
    v810_bus_resp #(
      .WAIT_MIN((g == 1) ? 3 : 0),
      .BUS16   ((g == 2) ? 1 : 0),
      .TIMEOUT (8)
    ) u_dut (
      .CLK(CLK), .RES(RES), .CE(CE), .A(A), .D_I(D_I), .D_O(d_o[g]),
      .BEn(BEn), .DAn(DAn), .MRQn(MRQn), .RW(RW), .BCYSTn(BCYSTn),
      .READYn(readyn[g]), .SZRQn(szrqn[g]), .M_A(m_a[g]), .M_BE(m_be[g]),
      .M_WR(m_wr[g]), .M_WD(m_wd[g]), .M_REQ(m_req[g]), .M_RD(M_RD),
`ifdef V810_BUS_RESP_TIMEOUT_EN
      .ERR(err[g]),
`endif
      .M_ACK(M_ACK)
    );
  end

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [3:0]  ben;
    logic        rw;
    logic [31:0] di;
    logic [31:0] mrd;
    int          ack_dly;
    logic [29:0] e_ma;
    logic [3:0]  e_mbe;
    logic [31:0] e_wd;
    logic [31:0] e_wdm;
    logic        e_sz;
    int          e_lat;
    logic [31:0] e_do;
  } vec_t;

  vec_t tv[10];

  function automatic vec_t mk(int k, logic [31:0] a, logic [3:0] ben, logic rw, logic [31:0] di,
                              logic [31:0] mrd, int dly, logic [29:0] ma, logic [3:0] mbe,
                              logic [31:0] wd, logic [31:0] wdm, logic sz, int lat, logic [31:0] dout);
    vec_t v;
    v.k = k; v.a = a; v.ben = ben; v.rw = rw; v.di = di; v.mrd = mrd; v.ack_dly = dly;
    v.e_ma = ma; v.e_mbe = mbe; v.e_wd = wd; v.e_wdm = wdm; v.e_sz = sz; v.e_lat = lat; v.e_do = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    BCYSTn = 1'b1; MRQn = 1'b1; DAn = 1'b1; M_ACK = 1'b0;
    repeat (n) step();
  endtask

  task automatic txn(input vec_t v, input string tag);
    int n;
    bit done;
    BCYSTn = 1'b0; MRQn = 1'b0; A = v.a; BEn = v.ben; RW = v.rw;
    step();
    BCYSTn = 1'b1; MRQn = 1'b1; D_I = v.di; M_RD = v.mrd; M_ACK = (v.ack_dly == 0);
    smp();
    chk({tag, " m_req"}, 32'(m_req[v.k]), 32'd1);
    chk({tag, " m_a"},   32'(m_a[v.k]),   32'(v.e_ma));
    chk({tag, " m_be"},  32'(m_be[v.k]),  32'(v.e_mbe));
    chk({tag, " m_wr"},  32'(m_wr[v.k]),  32'(!v.rw));
    chk({tag, " szrqn"}, 32'(szrqn[v.k]), 32'(v.e_sz));
    if (!v.rw) chk({tag, " m_wd"}, m_wd[v.k] & v.e_wdm, v.e_wd & v.e_wdm);
    n = 1; done = 1'b0;
    while (!done && n < 40) begin
      if (readyn[v.k] == 1'b0) begin
        done = 1'b1;
      end else begin
        step();
        n++;
        D_I = ~v.di;
        M_ACK = (n == 1 + v.ack_dly);
        smp();
      end
    end
    M_ACK = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(v.e_lat));
    if (v.rw) chk({tag, " d_o"}, d_o[v.k], v.e_do);
    else      chk({tag, " m_wd hold"}, m_wd[v.k] & v.e_wdm, v.e_wd & v.e_wdm);
    step(); smp();
    chk({tag, " readyn one cycle"}, 32'(readyn[v.k]), 32'd1);
    idle(8);
  endtask

  initial begin
    bit seen_rdy;
    int n;
    tv[0] = mk(0, 32'h0000_1004, 4'b0000, 1'b1, 32'h0,         32'hDEAD_BEEF, 0, 30'h401,  4'b1111, 32'h0,         32'h0,         1'b1, 2, 32'hDEAD_BEEF);
    tv[1] = mk(1, 32'h0000_2000, 4'b1100, 1'b0, 32'h1234_5678, 32'h0,         0, 30'h800,  4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 5, 32'h0);
    tv[2] = mk(2, 32'h0000_3000, 4'b0000, 1'b1, 32'h0,         32'hAAAA_5555, 0, 30'hC00,  4'b0011, 32'h0,         32'h0,         1'b0, 2, 32'h5555_5555);
    tv[3] = mk(2, 32'h0000_3002, 4'b0011, 1'b1, 32'h0,         32'hAAAA_5555, 0, 30'hC00,  4'b1100, 32'h0,         32'h0,         1'b0, 2, 32'hAAAA_AAAA);
    tv[4] = mk(2, 32'h0000_4002, 4'b0011, 1'b0, 32'h0000_C0DE, 32'h0,         0, 30'h1000, 4'b1100, 32'hC0DE_0000, 32'hFFFF_0000, 1'b0, 2, 32'h0);
    tv[5] = mk(0, 32'h0000_5008, 4'b1111, 1'b1, 32'h0,         32'h0102_0304, 0, 30'h1402, 4'b0000, 32'h0,         32'h0,         1'b1, 2, 32'h0102_0304);
    tv[6] = mk(0, 32'h0000_600C, 4'b1010, 1'b0, 32'hAABB_CCDD, 32'h0,         3, 30'h1803, 4'b0101, 32'hAABB_CCDD, 32'hFFFF_FFFF, 1'b1, 5, 32'h0);
    tv[7] = mk(1, 32'h0000_7000, 4'b0000, 1'b1, 32'h0,         32'h0BAD_F00D, 5, 30'h1C00, 4'b1111, 32'h0,         32'h0,         1'b1, 7, 32'h0BAD_F00D);
    tv[8] = mk(2, 32'h0000_8000, 4'b1110, 1'b1, 32'h0,         32'h1234_5678, 0, 30'h2000, 4'b0001, 32'h0,         32'h0,         1'b0, 2, 32'h5678_5678);
    tv[9] = mk(1, 32'h0000_9004, 4'b0000, 1'b0, 32'h55AA_55AA, 32'h0,         0, 30'h2401, 4'b1111, 32'h55AA_55AA, 32'hFFFF_FFFF, 1'b1, 5, 32'h0);

    RES = 1'b1; CE = 1'b1; DAn = 1'b1; MRQn = 1'b1; RW = 1'b1; BCYSTn = 1'b1; M_ACK = 1'b0;
    A = 32'h0; D_I = 32'h0; M_RD = 32'h0; BEn = 4'hF;
    step(); step();
    RES = 1'b0;
    smp();
    for (int k = 0; k < 3; k++) begin
      chk("reset readyn", 32'(readyn[k]), 32'd1);
      chk("reset szrqn",  32'(szrqn[k]),  32'd1);
      chk("reset m_req",  32'(m_req[k]),  32'd0);
      chk("reset d_o",    d_o[k],         32'd0);
`ifdef V810_BUS_RESP_TIMEOUT_EN
      chk("reset err",    32'(err[k]),    32'd0);
`endif
    end
    idle(2);

    for (int i = 0; i < 10; i++) txn(tv[i], $sformatf("vec%0d", i));

    // back-to-back halfword reads on the 16-bit device
    BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_3000; BEn = 4'b0000; RW = 1'b1;
    step(); BCYSTn = 1'b1; MRQn = 1'b1; M_ACK = 1'b1; M_RD = 32'hAAAA_5555;
    step(); M_ACK = 1'b0; smp();
    chk("b2b rdy1",   32'(readyn[2]), 32'd0);
    chk("b2b d_o1",   32'(d_o[2][15:0]), 32'h5555);
    chk("b2b szrqn1", 32'(szrqn[2]), 32'd0);
    step(); BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_3002; BEn = 4'b0011;
    step(); BCYSTn = 1'b1; MRQn = 1'b1; M_ACK = 1'b1; smp();
    chk("b2b m_req2", 32'(m_req[2]), 32'd1);
    chk("b2b m_be2",  32'(m_be[2]),  32'b1100);
    chk("b2b szrqn2", 32'(szrqn[2]), 32'd0);
    step(); M_ACK = 1'b0; smp();
    chk("b2b rdy2",   32'(readyn[2]), 32'd0);
    chk("b2b d_o2",   32'(d_o[2][15:0]), 32'hAAAA);
    idle(8);

    // reset in the 3rd MEM cycle, late ack in cycle 6 must be ignored
    BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_A000; BEn = 4'b0000; RW = 1'b1;
    step(); BCYSTn = 1'b1; MRQn = 1'b1;
    step(); step(); RES = 1'b1; smp();
    chk("rst m_req before", 32'(m_req[0]), 32'd1);
    step(); RES = 1'b0; smp();
    chk("rst m_req after",  32'(m_req[0]), 32'd0);
    chk("rst readyn after", 32'(readyn[0]), 32'd1);
    seen_rdy = 1'b0;
    for (int c = 5; c < 10; c++) begin
      step(); M_ACK = (c == 6); M_RD = 32'h7777_7777; smp();
      if (readyn[0] == 1'b0 || m_req[0] == 1'b1) seen_rdy = 1'b1;
    end
    chk("rst late ack ignored", 32'(seen_rdy), 32'd0);
    idle(2);
    txn(mk(0, 32'h0000_A004, 4'b0000, 1'b1, 32'h0, 32'h600D_CAFE, 0, 30'h2801, 4'b1111,
           32'h0, 32'h0, 1'b1, 2, 32'h600D_CAFE), "post-reset");

    // CE low freezes MEM and stretches RDY
    BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_B000; BEn = 4'b0000; RW = 1'b1;
    step(); BCYSTn = 1'b1; MRQn = 1'b1; CE = 1'b0; M_ACK = 1'b1; M_RD = 32'h1111_1111; smp();
    chk("ce m_req c1", 32'(m_req[0]), 32'd1);
    step(); M_ACK = 1'b0; smp();
    chk("ce m_req c2",  32'(m_req[0]),  32'd1);
    chk("ce readyn c2", 32'(readyn[0]), 32'd1);
    step(); CE = 1'b1; M_ACK = 1'b1; M_RD = 32'h2222_2222;
    step(); M_ACK = 1'b0; CE = 1'b0; smp();
    chk("ce readyn c4", 32'(readyn[0]), 32'd0);
    chk("ce d_o",       d_o[0],         32'h2222_2222);
    step(); CE = 1'b1; smp();
    chk("ce readyn held", 32'(readyn[0]), 32'd0);
    step(); smp();
    chk("ce readyn release", 32'(readyn[0]), 32'd1);
    idle(8);

    // MRQn high with BCYSTn low is not a memory cycle
    BCYSTn = 1'b0; MRQn = 1'b1; A = 32'h0000_C000;
    step(); BCYSTn = 1'b1; smp();
    chk("mrqn high m_req", 32'(m_req[0]), 32'd0);
    idle(2);

    // T1-skip start via DAn
    DAn = 1'b0; MRQn = 1'b0; BCYSTn = 1'b1; A = 32'h0000_C010; BEn = 4'b0000; RW = 1'b1;
    step(); DAn = 1'b1; MRQn = 1'b1; M_ACK = 1'b1; M_RD = 32'hCAFE_F00D; smp();
    chk("t1skip m_req", 32'(m_req[0]), 32'd1);
    chk("t1skip m_a",   32'(m_a[0]),   32'h3004);
    step(); M_ACK = 1'b0; smp();
    chk("t1skip readyn", 32'(readyn[0]), 32'd0);
    chk("t1skip d_o",    d_o[0],         32'hCAFE_F00D);
    idle(8);

`ifdef V810_BUS_RESP_TIMEOUT_EN
    BCYSTn = 1'b0; MRQn = 1'b0; A = 32'h0000_D000; BEn = 4'b0000; RW = 1'b1;
    step(); BCYSTn = 1'b1; MRQn = 1'b1; M_ACK = 1'b0; smp();
    n = 1;
    while (readyn[0] == 1'b1 && n < 40) begin
      step(); n++; smp();
    end
    chk("tmo latency", 32'(n), 32'd9);
    chk("tmo d_o",     d_o[0], 32'hFFFF_FFFF);
    chk("tmo err",     32'(err[0]), 32'd1);
    step(); smp();
    chk("tmo err pulse", 32'(err[0]), 32'd0);
    chk("tmo readyn",    32'(readyn[0]), 32'd1);
    idle(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
